wb_regfile: RTL and testbench

- Consumer end of the MEM/WB pipeline interface: takes the write-back bundle (write enable, destination register, data, debug PC+4) and commits it to the architectural integer register file.
- Serves the two combinational read ports used by the ID stage, with same-cycle write-to-read bypass.
- Keeps a retired-instruction counter and a last-retired-PC register for debug/trace.

---
 rtl/wb_regfile_pkg.sv | 14 +
 rtl/wb_regfile_rf_read_port.sv | 21 ++
 rtl/wb_regfile.sv | 84 ++++++++
 tb/tb_wb_regfile.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared CPU constants and the MEM/WB write-back bundle type
package wb_regfile_pkg;
    localparam int XLEN       = 32;
    localparam int AW         = 5;
    localparam int ZERO_REG   = 0;
    localparam int SQUASH_BIT = 31;

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   wR;
        logic [XLEN-1:0] wD;
        logic [XLEN-1:0] pc4;
    } wb_bundle_t;
endpackage

// File: rtl/wb_regfile_rf_read_port.sv
// rf_read_port: one combinational register read with x0 forcing and write bypass
module rf_read_port
    import wb_regfile_pkg::*;
#(
    parameter int XLEN   = wb_regfile_pkg::XLEN,
    parameter int AW     = wb_regfile_pkg::AW,
    parameter bit BYPASS = 1'b1
) (
    input  logic [AW-1:0]   rs_i,
    input  logic [XLEN-1:0] reg_data_i,
    input  logic            we_eff_i,
    input  logic [AW-1:0]   wr_i,
    input  logic [XLEN-1:0] wd_i,
    output logic [XLEN-1:0] rd_o
);
    // x0 wins over bypass; bypass only for a live, unsquashed write
    always_comb begin
        rd_o = (rs_i == AW'(ZERO_REG)) ? '0 :
               (BYPASS && we_eff_i && rs_i == wr_i) ? wd_i : reg_data_i;
    end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back commit into the integer register file plus retire trace
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int XLEN   = wb_regfile_pkg::XLEN,
    parameter int AW     = wb_regfile_pkg::AW,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_reg_we_i,
    input  logic [AW-1:0]   wb_wR_i,
    input  logic [XLEN-1:0] wb_wD_i,
    input  logic [XLEN-1:0] wb_pc4_i_debug,
    input  logic [AW-1:0]   rs1_i,
    input  logic [AW-1:0]   rs2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    output logic [31:0]     retire_cnt_o,
    output logic [XLEN-1:0] last_pc_o,
    output logic            dbg_commit_o
);
    localparam int NREG = 2 ** AW;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [31:0]     retire_cnt_q, retire_cnt_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;
    logic            dbg_commit_q, dbg_commit_d;
    logic            squash, we_eff, retire;

    // Squash bit in the debug PC guards against any bundle MEM/WB failed to kill
    always_comb begin
        squash = wb_pc4_i_debug[SQUASH_BIT];
        we_eff = wb_reg_we_i && !squash && (wb_wR_i != AW'(ZERO_REG));
        retire = (wb_pc4_i_debug != '0) && !squash;
    end

    // Next-state for register array and trace state
    always_comb begin
        regs_d = regs_q;
        if (we_eff) regs_d[wb_wR_i] = wb_wD_i;
        retire_cnt_d = retire ? retire_cnt_q + 32'd1 : retire_cnt_q;
        last_pc_d    = retire ? wb_pc4_i_debug - XLEN'(4) : last_pc_q;
        dbg_commit_d = we_eff;
    end

    // State update; reset drops any write presented in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            retire_cnt_q <= '0;
            last_pc_q    <= '0;
            dbg_commit_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            retire_cnt_q <= retire_cnt_d;
            last_pc_q    <= last_pc_d;
            dbg_commit_q <= dbg_commit_d;
        end
    end

    assign retire_cnt_o = retire_cnt_q;
    assign last_pc_o    = last_pc_q;
    assign dbg_commit_o = dbg_commit_q;

    rf_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rp1 (
        .rs_i       (rs1_i),
        .reg_data_i (regs_q[rs1_i]),
        .we_eff_i   (we_eff),
        .wr_i       (wb_wR_i),
        .wd_i       (wb_wD_i),
        .rd_o       (rd1_o)
    );

    rf_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rp2 (
        .rs_i       (rs2_i),
        .reg_data_i (regs_q[rs2_i]),
        .we_eff_i   (we_eff),
        .wr_i       (wb_wR_i),
        .wd_i       (wb_wD_i),
        .rd_o       (rd2_o)
    );
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vector bench driving a bypass and a no-bypass instance in parallel
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [4:0]  rs1, rs2;
    logic [31:0] b_rd1, b_rd2, b_cnt, b_last;
    logic [31:0] n_rd1, n_rd2, n_cnt, n_last;
    logic        b_commit, n_commit;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    wb_regfile #(.BYPASS(1'b1)) dut_b (
        .clk(clk), .rst(rst), .wb_reg_we_i(we), .wb_wR_i(wr), .wb_wD_i(wd),
        .wb_pc4_i_debug(pc4), .rs1_i(rs1), .rs2_i(rs2), .rd1_o(b_rd1), .rd2_o(b_rd2),
        .retire_cnt_o(b_cnt), .last_pc_o(b_last), .dbg_commit_o(b_commit)
    );

    wb_regfile #(.BYPASS(1'b0)) dut_n (
        .clk(clk), .rst(rst), .wb_reg_we_i(we), .wb_wR_i(wr), .wb_wD_i(wd),
        .wb_pc4_i_debug(pc4), .rs1_i(rs1), .rs2_i(rs2), .rd1_o(n_rd1), .rd2_o(n_rd2),
        .retire_cnt_o(n_cnt), .last_pc_o(n_last), .dbg_commit_o(n_commit)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] b_rd1;
        logic [31:0] b_rd2;
        logic [31:0] n_rd1;
        logic [31:0] n_rd2;
        logic [31:0] cnt;
        logic [31:0] last;
        logic        commit;
    } vec_t;

    vec_t v [14];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] p, input logic [4:0] s1, input logic [4:0] s2);
        rst = r; we = w; wr = a; wd = d; pc4 = p; rs1 = s1; rs2 = s2;
    endtask

    initial begin
        //        rst we  wR  wD            pc4           rs1 rs2 b_rd1         b_rd2         n_rd1         n_rd2         cnt   last          commit
        v[0]  = '{0, 1, 5, 32'hDEADBEEF, 32'h00000008, 5, 0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        1, 32'h4,        1};
        v[1]  = '{0, 0, 0, 32'h0,        32'h00000000, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1, 32'h4,        0};
        v[2]  = '{0, 1, 7, 32'h00001234, 32'h0000000C, 7, 7, 32'h1234,     32'h1234,     32'h0,        32'h0,        2, 32'h8,        1};
        v[3]  = '{0, 0, 0, 32'h0,        32'h00000000, 7, 5, 32'h1234,     32'hDEADBEEF, 32'h1234,     32'hDEADBEEF, 2, 32'h8,        0};
        v[4]  = '{0, 1, 0, 32'hFFFFFFFF, 32'h00000010, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        3, 32'hC,        0};
        v[5]  = '{0, 1, 3, 32'h000000AA, 32'h80000010, 3, 3, 32'h0,        32'h0,        32'h0,        32'h0,        3, 32'hC,        0};
        v[6]  = '{0, 0, 0, 32'h0,        32'h00000000, 3, 0, 32'h0,        32'h0,        32'h0,        32'h0,        3, 32'hC,        0};
        v[7]  = '{0, 0, 5, 32'h00000077, 32'h00000020, 5, 7, 32'hDEADBEEF, 32'h1234,     32'hDEADBEEF, 32'h1234,     4, 32'h1C,       0};
        v[8]  = '{0, 1, 5, 32'hCAFEF00D, 32'h00000024, 5, 7, 32'hCAFEF00D, 32'h1234,     32'hDEADBEEF, 32'h1234,     5, 32'h20,       1};
        v[9]  = '{1, 1, 9, 32'h00000055, 32'h00000028, 9, 5, 32'h55,       32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 0, 32'h0,        0};
        v[10] = '{0, 0, 0, 32'h0,        32'h00000000, 9, 5, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        0};
        v[11] = '{0, 1, 9, 32'h00000099, 32'h00000004, 9, 1, 32'h99,       32'h0,        32'h0,        32'h0,        1, 32'h0,        1};
        v[12] = '{0, 0, 0, 32'h0,        32'h00000000, 9, 9, 32'h99,       32'h99,       32'h99,       32'h99,       1, 32'h0,        0};
        v[13] = '{0, 0, 0, 32'h0,        32'h00000002, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        2, 32'hFFFFFFFE, 0};

        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_cnt", 0, b_cnt, 32'h0);
        chk("rst_last", 0, b_last, 32'h0);
        chk("rst_commit", 0, {31'h0, b_commit}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
            #1;
            chk("rst_rd1", i, b_rd1, 32'h0);
            chk("rst_rd2", i, b_rd2, 32'h0);
            chk("rst_nrd1", i, n_rd1, 32'h0);
        end

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(v[i].rst, v[i].we, v[i].wr, v[i].wd, v[i].pc4, v[i].rs1, v[i].rs2);
            #1;
            chk("b_rd1", i, b_rd1, v[i].b_rd1);
            chk("b_rd2", i, b_rd2, v[i].b_rd2);
            chk("n_rd1", i, n_rd1, v[i].n_rd1);
            chk("n_rd2", i, n_rd2, v[i].n_rd2);
            @(posedge clk);
            #1;
            chk("b_cnt", i, b_cnt, v[i].cnt);
            chk("b_last", i, b_last, v[i].last);
            chk("b_commit", i, {31'h0, b_commit}, {31'h0, v[i].commit});
            chk("n_cnt", i, n_cnt, v[i].cnt);
            chk("n_commit", i, {31'h0, n_commit}, {31'h0, v[i].commit});
        end

        // retire counter wrap: preload all-ones, then retire once
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        force dut_b.retire_cnt_q = 32'hFFFFFFFF;
        force dut_n.retire_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut_b.retire_cnt_q;
        release dut_n.retire_cnt_q;
        @(posedge clk);
        #1;
        chk("preload", 0, b_cnt, 32'hFFFFFFFF);
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h00000008, 0, 0);
        @(posedge clk);
        #1;
        chk("wrap_cnt", 0, b_cnt, 32'h0);
        chk("wrap_ncnt", 0, n_cnt, 32'h0);
        chk("wrap_last", 0, b_last, 32'h4);

        // mid-stream reset then immediate write commits normally
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 9, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1, 12, 32'h0BADF00D, 32'h00000100, 12, 9);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 12, 9);
        #1;
        chk("post_rst_rd1", 0, n_rd1, 32'h0BADF00D);
        chk("post_rst_rd2", 0, n_rd2, 32'h0);
        chk("post_rst_cnt", 0, b_cnt, 32'h1);
        chk("post_rst_last", 0, b_last, 32'hFC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
